// File: rtl/wb_merge_pkg.sv
// Shared types and default widths for the writeback merge stage.
// Optional build macro: WB_MERGE_BYPASS_EN (see wb_merge.sv).
package wb_merge_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 64;

    // One pending register-file write: destination index and data.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Writes to x0 are consumed but never reach the register file.
    function automatic logic wb_is_x0(input logic [WB_ADDR_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/wb_merge_fifo.sv
// In-order holding FIFO for ALU writebacks that lose arbitration.
// Power-of-two depth; pointers wrap naturally at their bit width.
module wb_fifo
    import wb_merge_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     din,
    output wb_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointer and occupancy values from the qualified push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/wb_merge.sv
// Writeback merge: LSU loads beat ALU results onto the single RF write port.
// Define WB_MERGE_BYPASS_EN to let an idle-cycle ALU result skip the FIFO.
module wb_merge
    import wb_merge_pkg::*;
#(
    parameter  int ADDR_WIDTH = WB_ADDR_W,
    parameter  int DATA_WIDTH = WB_DATA_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [CW-1:0]         pending
);

    wb_entry_t       alu_ent;
    wb_entry_t       lsu_ent;
    wb_entry_t       head;
    wb_entry_t       sel;
    wb_entry_t       out_q, out_d;
    logic            wen_q, wen_d;
    logic            sel_valid;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            alu_acc;
    logic [CW-1:0]   count;

    assign alu_ent = '{rd: alu_rd, data: alu_data};
    assign lsu_ent = '{rd: lsu_rd, data: lsu_data};

    // Ready depends only on occupancy, so a full FIFO always costs a cycle.
    assign alu_ready = (count != CW'(FIFO_DEPTH));
    assign alu_acc   = alu_valid & alu_ready;
    assign pending   = count;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (alu_ent),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // Pick this cycle's write: LSU, then FIFO head, then a fresh ALU result.
    always_comb begin
        sel       = out_q;
        sel_valid = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (lsu_valid) begin
            sel       = lsu_ent;
            sel_valid = 1'b1;
            push      = alu_acc;
        end else if (!fifo_empty) begin
            sel       = head;
            sel_valid = 1'b1;
            pop       = 1'b1;
            push      = alu_acc;
        end else if (alu_acc) begin
`ifdef WB_MERGE_BYPASS_EN
            sel       = alu_ent;
            sel_valid = 1'b1;
`else
            push      = 1'b1;
`endif
        end
    end

    // Output register holds its last address/data on idle cycles.
    always_comb begin
        out_d = out_q;
        wen_d = 1'b0;
        if (sel_valid) begin
            out_d = sel;
            wen_d = ~wb_is_x0(sel.rd);
        end
    end

    // Registered write port, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            wen_q <= 1'b0;
        end else begin
            out_q <= out_d;
            wen_q <= wen_d;
        end
    end

    assign rf_wen   = wen_q;
    assign rf_waddr = out_q.rd;
    assign rf_wdata = out_q.data;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule
